// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; master issues requests, slave computes.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // rem_in < divisor always holds, so the trial difference fits in WIDTH bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider: one quotient bit per cycle, sign fix-up on exit.
//   state  | meaning
//   IDLE   | waiting for start; operands and sign flags captured on start
//   RUN    | WIDTH shift-subtract steps, busy=1
//   FINISH | one-cycle done pulse, results registered on entry
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvsr_mag;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   quotient_r, remainder_r;
  logic               div_zero_r;

  logic               busy_c, done_c, accept, step_en, last_step;
  logic               dvd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   step_rem, q_mag, q_fix, r_fix;
  logic               step_q;

  always_comb begin
    dvd_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    dvs_neg   = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag   = dvs_neg ? -bus.divisor : bus.divisor;
    dvs_zero  = (bus.divisor == '0);
    last_step = (cnt == CNT_W'(1));
  end

  // acc = {partial remainder, dividend bits still to shift / quotient bits so far}
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (acc[2*WIDTH-1:WIDTH]),
    .bit_in  (acc[WIDTH-1]),
    .divisor (dvsr_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    q_mag = {acc[WIDTH-2:0], step_q};
    q_fix = neg_q ? -q_mag : q_mag;
    r_fix = neg_r ? -step_rem : step_rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = dvs_zero ? FINISH : RUN;
      RUN:     if (last_step) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state == RUN);
    done_c  = (state == FINISH);
    accept  = (state == IDLE) & bus.start;
    step_en = (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      dvsr_mag    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else if (accept) begin
      cnt      <= CNT_W'(WIDTH);
      acc      <= {{WIDTH{1'b0}}, dvd_mag};
      dvsr_mag <= dvs_mag;
      neg_q    <= dvd_neg ^ dvs_neg;
      neg_r    <= dvd_neg;
      if (dvs_zero) begin
        quotient_r  <= '1;
        remainder_r <= bus.dividend;
        div_zero_r  <= 1'b1;
      end
    end else if (step_en) begin
      cnt <= cnt - CNT_W'(1);
      acc <= {step_rem, q_mag};
      if (last_step) begin
        quotient_r  <= q_fix;
        remainder_r <= r_fix;
        div_zero_r  <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=32: vector table, random ops, corner sequences.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference built on native 64-bit division (truncates toward zero).
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint na, nb, q, r;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
      return e;
    end
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'b0, a});
      nb = longint'({32'b0, b});
    end
    q = na / nb;
    r = na % nb;
    e.q = q[W-1:0]; e.r = r[W-1:0]; e.dz = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 64'(bus.quotient), 64'(e.q));
        check("remainder", 64'(bus.remainder), 64'(e.r));
        check("div_zero", 64'(bus.div_zero), 64'(e.dz));
      end
    end
  end

  // Issue one op in the IDLE cycle, then count samples until done.
  // inject_at > 0 drives a bogus start at that sample, which must be ignored.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int inject_at);
    int lat, busy_n;
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
    sb.push_back(e);
    lat = -1; busy_n = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (n == inject_at) begin
        check("busy_at_inject", 64'(bus.busy), 64'd1);
        bus.start = 1'b1; bus.is_signed = ~sgn;
        bus.dividend = 32'h0000_1234; bus.divisor = 32'h0;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check("latency", 64'(lat), e.dz ? 64'd1 : 64'(W + 1));
    check("busy_cycles", 64'(busy_n), e.dz ? 64'd0 : 64'(W));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    exp_t e;
    int   dn;

    vt[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{1'b0, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 32'h1,         1'b0};
    vt[3]  = '{1'b0, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         1'b1};
    vt[4]  = '{1'b1, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         1'b1};
    vt[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0};
    vt[6]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         1'b0};
    vt[7]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 1'b0};
    vt[8]  = '{1'b0, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0};
    vt[9]  = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
    vt[10] = '{1'b1, 32'hFFFF_FFFF, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vt[11] = '{1'b0, 32'd0,         32'd3,         32'd0,         32'd0,         1'b0};
    vt[12] = '{1'b1, 32'h8000_0000, 32'h0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[13] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h1,         32'h0,         1'b0};
    vt[14] = '{1'b1, 32'h8000_0000, 32'h2,         32'hC000_0000, 32'h0,         1'b0};

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    reset = 1'b0;

    // Vector table, issued back to back.
    for (int i = 0; i < 15; i++) begin
      e.q = vt[i].q; e.r = vt[i].r; e.dz = vt[i].dz;
      run_op(vt[i].sgn, vt[i].a, vt[i].b, e, 0);
    end

    // Results hold while idle.
    repeat (5) @(negedge clk);
    check("hold_quotient", 64'(bus.quotient), 64'hC000_0000);
    check("hold_remainder", 64'(bus.remainder), 64'h0);

    // Random operations against the native-division model.
    for (int i = 0; i < 24; i++) begin
      logic         sgn;
      logic [W-1:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 9));
        1:       b = 32'($urandom_range(0, 1)) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_op(sgn, a, b, model(sgn, a, b), 0);
    end

    // Reset mid-run: previous result is 100/7 so a cleared output is observable.
    e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, e, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd200; bus.divisor = 32'd3;
    sb.push_back(model(1'b0, 32'd200, 32'd3));
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_quotient", 64'(bus.quotient), 64'd0);
    check("abort_remainder", 64'(bus.remainder), 64'd0);
    check("abort_div_zero", 64'(bus.div_zero), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("no_done_after_abort", 64'(dn), 64'd0);

    // Start during RUN is ignored; original operation completes correctly.
    e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, e, 3);
    e = model(1'b1, 32'hFFFF_FF9C, 32'd7);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, e, 5);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits (legal range 2..64).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request pulse; sampled only when idle.
REQ-005 is_signed  in  1  1 = two's-complement operation, 0 = unsigned; sampled with start.
REQ-006 dividend  in  WIDTH  numerator; sampled with start.
REQ-007 divisor  in  WIDTH  denominator; sampled with start.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  one-cycle pulse; results valid from this cycle.
REQ-010 quotient  out  WIDTH  registered quotient.
REQ-011 remainder  out  WIDTH  registered remainder.
REQ-012 div_zero  out  1  registered flag; divisor was zero for the last completed operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, FINISH.
REQ-014 In IDLE, start=1 at an edge SHALL latch the operands and is_signed, take operand magnitudes (when signed), load the iteration counter with WIDTH, and enter RUN; if divisor==0, it SHALL enter FINISH instead.
REQ-015 start while busy=1 SHALL be ignored without side effects.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes, then decrement the counter, and SHALL exit to FINISH after exactly WIDTH steps.
REQ-017 FINISH SHALL last one cycle: done=1, busy=0, and quotient, remainder and div_zero updated in that same cycle; the next state SHALL be IDLE.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in FINISH.
REQ-019 Latency: for a start sampled at edge N, done SHALL be high during the cycle after edge N+WIDTH+1 (divisor nonzero), or after edge N+1 (divisor zero).
REQ-020 Signed results SHALL truncate toward zero: quotient negative iff operand signs differ and the quotient is nonzero; remainder sign SHALL equal the dividend sign.
REQ-021 Divide by zero SHALL give quotient = all ones, remainder = dividend unmodified, and div_zero=1; otherwise div_zero=0.
REQ-022 Signed overflow (most-negative / -1) SHALL give quotient = most-negative and remainder = 0, with no special-case flag.
REQ-023 Outputs SHALL hold their values from FINISH until the next FINISH.
REQ-024 A start in the cycle after done SHALL be accepted; back-to-back operations SHALL need no idle gap beyond the FINISH cycle.
REQ-025 Internal datapath width SHALL be 2*WIDTH; magnitude of the most-negative value SHALL be handled without overflow.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0, and all internal registers to 0.
REQ-027 reset asserted mid-operation SHALL abort the operation, and no done pulse SHALL follow for it.
REQ-028 reset has priority over start.

Structure
REQ-029 Package div_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-030 One combinational sub-module, div_step, SHALL implement a single shift-subtract step (remainder/divisor in, next remainder and quotient bit out); seq_divider SHALL instantiate it once.
REQ-031 Sign fix-up and magnitude conversion SHALL stay in seq_divider.

Verification (WIDTH=32)
REQ-032 Unsigned 100/7, start at edge 0 -> quotient=14, remainder=2, done high after edge 33, busy high cycles 1..32.
REQ-033 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-034 7/0 (either mode) -> div_zero=1, quotient=0xFFFFFFFF, remainder=7, done after edge 1.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
REQ-036 reset pulsed at cycle 10 of a run -> busy=0 and all outputs 0 immediately, no done; a new start at cycle 3 of the next run is ignored, and the original result is correct.
